// File: rtl/pc_fetch_pkg.sv
// ============================================================================
// Module   : pc_fetch_pkg
// Purpose  : Shared types and constants for the PC fetch unit.
//            - fetch_state_e : fetch FSM state encoding (IDLE / REQ / WAIT)
//            - PC_INCR       : sequential PC increment (bytes per instruction)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // no fetch outstanding
    REQ  = 2'd1,   // request presented to instruction memory
    WAIT = 2'd2    // request accepted, waiting for read data
  } fetch_state_e;

  localparam int unsigned PC_INCR = 4;

endpackage : pc_fetch_pkg

`default_nettype wire

// File: rtl/pc_fetch_if.sv
// ============================================================================
// Module   : pc_fetch_if
// Purpose  : Instruction-memory request/response bundle of the fetch unit.
// Signals  : PC_FETCH_Req_Valid / PC_FETCH_Req_Ready / PC_FETCH_Req_Addr
//            PC_FETCH_Rsp_Valid / PC_FETCH_Rsp_Data
// Modports : master - fetch unit side (drives request, receives response)
//            slave  - memory side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_if #(
  parameter int XLEN = 32
) ();

  logic            PC_FETCH_Req_Valid;
  logic            PC_FETCH_Req_Ready;
  logic [XLEN-1:0] PC_FETCH_Req_Addr;
  logic            PC_FETCH_Rsp_Valid;
  logic [XLEN-1:0] PC_FETCH_Rsp_Data;

  modport master (
    output PC_FETCH_Req_Valid,
    output PC_FETCH_Req_Addr,
    input  PC_FETCH_Req_Ready,
    input  PC_FETCH_Rsp_Valid,
    input  PC_FETCH_Rsp_Data
  );

  modport slave (
    input  PC_FETCH_Req_Valid,
    input  PC_FETCH_Req_Addr,
    output PC_FETCH_Req_Ready,
    output PC_FETCH_Rsp_Valid,
    output PC_FETCH_Rsp_Data
  );

endinterface : pc_fetch_if

`default_nettype wire

// File: rtl/pc_fetch_pending.sv
// ============================================================================
// Module   : pc_fetch_pending
// Purpose  : One-deep pending-advance register for the fetch unit.
// Ports    : clk_i, rst_ni       - clock, asynchronous active-low reset
//            set_i               - advance requested while a fetch is busy
//            clr_i               - pending entry consumed (fetch completes)
//            load_i, target_i    - advance kind and branch target
//            valid_o, load_o,
//            target_o            - stored pending entry
//            overrun_o           - sticky: an advance was dropped
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_pending #(
  parameter int XLEN = 32
) (
  input  wire logic            clk_i,
  input  wire logic            rst_ni,
  input  wire logic            set_i,
  input  wire logic            clr_i,
  input  wire logic            load_i,
  input  wire logic [XLEN-1:0] target_i,
  output logic                 valid_o,
  output logic                 load_o,
  output logic [XLEN-1:0]      target_o,
  output logic                 overrun_o
);

  logic            valid_q,   valid_d;
  logic            load_q,    load_d;
  logic [XLEN-1:0] target_q,  target_d;
  logic            overrun_q, overrun_d;

  always_comb begin
    valid_d   = valid_q;
    load_d    = load_q;
    target_d  = target_q;
    overrun_d = overrun_q;
    // An occupied entry always wins: the newcomer is dropped, even in the
    // cycle the entry is consumed.
    if (set_i && valid_q) begin
      overrun_d = 1'b1;
    end
    // A set arriving together with clr and an empty entry is applied
    // directly by the caller, so it is not stored here.
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (set_i && !valid_q) begin
      valid_d  = 1'b1;
      load_d   = load_i;
      target_d = target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      load_q    <= 1'b0;
      target_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      load_q    <= load_d;
      target_q  <= target_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign load_o    = load_q;
  assign target_o  = target_q;
  assign overrun_o = overrun_q;

endmodule : pc_fetch_pending

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// Module   : pc_fetch
// Purpose  : Program counter and instruction fetch sequencer. Each accepted
//            Set_En advances the PC (PC+4 or Target) and fetches one
//            instruction over the memory interface; one advance arriving
//            while busy is queued, further ones are dropped (Overrun).
// Ports    : PC_FETCH_Clk, PC_FETCH_Reset (async, active-low)
//            PC_FETCH_Set_En, PC_FETCH_Load, PC_FETCH_Target - advance request
//            mem_if (pc_fetch_if.master)                     - memory bus
//            PC_FETCH_Instr, PC_FETCH_Instr_Valid            - fetched word
//            PC_FETCH_PC, PC_FETCH_Overrun                   - status
//            PC_FETCH_Misalign (only with PC_FETCH_MISALIGN_CHECK_EN)
// Config   : PC_FETCH_MISALIGN_CHECK_EN - drop loads of non word-aligned
//            targets and flag them on PC_FETCH_Misalign.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  wire logic            PC_FETCH_Clk,
  input  wire logic            PC_FETCH_Reset,
  input  wire logic            PC_FETCH_Set_En,
  input  wire logic            PC_FETCH_Load,
  input  wire logic [XLEN-1:0] PC_FETCH_Target,
  pc_fetch_if.master           mem_if,
  output logic [XLEN-1:0]      PC_FETCH_Instr,
  output logic                 PC_FETCH_Instr_Valid,
  output logic [XLEN-1:0]      PC_FETCH_PC,
  output logic                 PC_FETCH_Overrun
`ifdef PC_FETCH_MISALIGN_CHECK_EN
  ,
  output logic                 PC_FETCH_Misalign
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;

  logic            adv_req;      // Set_En after optional alignment filter
  logic            rsp_fire;     // response accepted this cycle
  logic            pend_valid;
  logic            pend_load;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] pc_seq;

  assign pc_seq   = pc_q + XLEN'(PC_INCR);  // wraps modulo 2^XLEN
  assign rsp_fire = (state_q == WAIT) && mem_if.PC_FETCH_Rsp_Valid;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic bad_target;

  assign bad_target = PC_FETCH_Set_En && PC_FETCH_Load && (|PC_FETCH_Target[1:0]);
  assign adv_req    = PC_FETCH_Set_En && !bad_target;

  always_ff @(posedge PC_FETCH_Clk or negedge PC_FETCH_Reset) begin
    if (!PC_FETCH_Reset) begin
      misalign_q <= 1'b0;
    end else if (bad_target) begin
      misalign_q <= 1'b1;
    end
  end

  assign PC_FETCH_Misalign = misalign_q;
`else
  assign adv_req = PC_FETCH_Set_En;
`endif

  pc_fetch_pending #(
    .XLEN (XLEN)
  ) u_pending (
    .clk_i     (PC_FETCH_Clk),
    .rst_ni    (PC_FETCH_Reset),
    .set_i     (adv_req && (state_q != IDLE)),
    .clr_i     (rsp_fire),
    .load_i    (PC_FETCH_Load),
    .target_i  (PC_FETCH_Target),
    .valid_o   (pend_valid),
    .load_o    (pend_load),
    .target_o  (pend_target),
    .overrun_o (PC_FETCH_Overrun)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (adv_req) begin
          pc_d    = PC_FETCH_Load ? PC_FETCH_Target : pc_seq;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_if.PC_FETCH_Req_Ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_if.PC_FETCH_Rsp_Valid) begin
          instr_d       = mem_if.PC_FETCH_Rsp_Data;
          instr_valid_d = 1'b1;
          // A queued advance has priority over one arriving this cycle.
          if (pend_valid) begin
            pc_d    = pend_load ? pend_target : pc_seq;
            state_d = REQ;
          end else if (adv_req) begin
            pc_d    = PC_FETCH_Load ? PC_FETCH_Target : pc_seq;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PC_FETCH_Clk or negedge PC_FETCH_Reset) begin
    if (!PC_FETCH_Reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_if.PC_FETCH_Req_Valid = (state_q == REQ);
  assign mem_if.PC_FETCH_Req_Addr  = pc_q;
  assign PC_FETCH_Instr            = instr_q;
  assign PC_FETCH_Instr_Valid      = instr_valid_q;
  assign PC_FETCH_PC               = pc_q;

endmodule : pc_fetch

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// Module   : tb_pc_fetch
// Purpose  : Self-checking bench for pc_fetch. Expected instruction words are
//            queued when a response is driven and popped when Instr_Valid
//            is observed; PC / request / status checks are inline per test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            set_en;
  logic            load;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic            overrun;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
  logic            misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_instr = '0;

  pc_fetch_if #(.XLEN(XLEN)) bus ();

  pc_fetch #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .PC_FETCH_Clk         (clk),
    .PC_FETCH_Reset       (rst_n),
    .PC_FETCH_Set_En      (set_en),
    .PC_FETCH_Load        (load),
    .PC_FETCH_Target      (target),
    .mem_if               (bus.master),
    .PC_FETCH_Instr       (instr),
    .PC_FETCH_Instr_Valid (instr_valid),
    .PC_FETCH_PC          (pc),
    .PC_FETCH_Overrun     (overrun)
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    ,
    .PC_FETCH_Misalign    (misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input logic ld, input logic [XLEN-1:0] tgt);
    set_en = 1'b1;
    load   = ld;
    target = tgt;
    tick();
    set_en = 1'b0;
    load   = 1'b0;
    target = '0;
  endtask

  // Memory accepts the outstanding request.
  task automatic accept(input string tag);
    checks++;
    if (bus.PC_FETCH_Req_Valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_req_valid: got %b want 1", tag, bus.PC_FETCH_Req_Valid);
    end
    bus.PC_FETCH_Req_Ready = 1'b1;
    tick();
    bus.PC_FETCH_Req_Ready = 1'b0;
  endtask

  // Memory returns a word; the scoreboard entry is checked on Instr_Valid.
  task automatic respond(input logic [XLEN-1:0] data, input string tag);
    exp_q.push_back(data);
    bus.PC_FETCH_Rsp_Valid = 1'b1;
    bus.PC_FETCH_Rsp_Data  = data;
    tick();
    bus.PC_FETCH_Rsp_Valid = 1'b0;
    bus.PC_FETCH_Rsp_Data  = '0;
    checks++;
    if (instr_valid !== 1'b1 || exp_q.size() == 0 || instr !== exp_q[0]) begin
      errors++;
      $display("FAIL %s_instr: got valid=%b instr=%h want valid=1 instr=%h",
               tag, instr_valid, instr, data);
    end
    if (exp_q.size() != 0) last_instr = exp_q.pop_front();
  endtask

  task automatic test_reset();
    checks++;
    if (pc !== 32'h0 || bus.PC_FETCH_Req_Valid !== 1'b0 || instr !== 32'h0 ||
        instr_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h rv=%b instr=%h iv=%b ovr=%b want all 0",
               pc, bus.PC_FETCH_Req_Valid, instr, instr_valid, overrun);
    end
  endtask

  task automatic test_incr();
    advance(1'b0, '0);
    checks++;
    if (pc !== 32'h4 || bus.PC_FETCH_Req_Valid !== 1'b1 || bus.PC_FETCH_Req_Addr !== 32'h4) begin
      errors++;
      $display("FAIL incr_req: got pc=%h rv=%b addr=%h want pc=4 rv=1 addr=4",
               pc, bus.PC_FETCH_Req_Valid, bus.PC_FETCH_Req_Addr);
    end
    accept("incr");
    respond(32'h0000_0013, "incr");
  endtask

  task automatic test_load_stall();
    int pulses;
    advance(1'b1, 32'h100);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.PC_FETCH_Req_Valid !== 1'b1 || bus.PC_FETCH_Req_Addr !== 32'h100) begin
        errors++;
        $display("FAIL stall_addr[%0d]: got rv=%b addr=%h want rv=1 addr=100",
                 i, bus.PC_FETCH_Req_Valid, bus.PC_FETCH_Req_Addr);
      end
      if (i < 3) tick();
    end
    accept("stall");
    respond(32'h0050_0093, "stall");
    pulses = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (instr_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL stall_pulse: got pulses=%0d instr=%h want pulses=1 instr=00500093",
               pulses, instr);
    end
  endtask

  task automatic test_pending();
    advance(1'b0, '0);             // PC 0x100 -> 0x104
    accept("pend_a");
    advance(1'b1, 32'h200);        // recorded while in WAIT
    checks++;
    if (pc !== 32'h104 || bus.PC_FETCH_Req_Valid !== 1'b0) begin
      errors++;
      $display("FAIL pend_hold: got pc=%h rv=%b want pc=104 rv=0", pc, bus.PC_FETCH_Req_Valid);
    end
    tick();
    respond(32'h1111_1111, "pend_a");
    checks++;
    if (pc !== 32'h200 || bus.PC_FETCH_Req_Valid !== 1'b1 || bus.PC_FETCH_Req_Addr !== 32'h200) begin
      errors++;
      $display("FAIL pend_apply: got pc=%h rv=%b addr=%h want pc=200 rv=1 addr=200",
               pc, bus.PC_FETCH_Req_Valid, bus.PC_FETCH_Req_Addr);
    end
    accept("pend_b");
    respond(32'h2222_2222, "pend_b");
  endtask

  task automatic test_same_cycle();
    advance(1'b0, '0);             // 0x200 -> 0x204
    accept("same");
    exp_q.push_back(32'h3333_3333);
    bus.PC_FETCH_Rsp_Valid = 1'b1;
    bus.PC_FETCH_Rsp_Data  = 32'h3333_3333;
    set_en = 1'b1;
    load   = 1'b0;
    tick();
    set_en = 1'b0;
    bus.PC_FETCH_Rsp_Valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || exp_q.size() == 0 || instr !== exp_q[0]) begin
      errors++;
      $display("FAIL same_instr: got valid=%b instr=%h want valid=1 instr=33333333",
               instr_valid, instr);
    end
    if (exp_q.size() != 0) last_instr = exp_q.pop_front();
    checks++;
    if (pc !== 32'h208 || bus.PC_FETCH_Req_Valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL same_adv: got pc=%h rv=%b ovr=%b want pc=208 rv=1 ovr=0",
               pc, bus.PC_FETCH_Req_Valid, overrun);
    end
    accept("same_b");
    respond(32'h4444_4444, "same_b");
  endtask

  task automatic test_overrun();
    advance(1'b1, 32'h300);
    advance(1'b1, 32'h400);        // queued
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got %b want 0", overrun);
    end
    advance(1'b1, 32'h500);        // dropped
    advance(1'b1, 32'h600);        // dropped
    checks++;
    if (overrun !== 1'b1 || pc !== 32'h300 || bus.PC_FETCH_Req_Addr !== 32'h300) begin
      errors++;
      $display("FAIL ovr_set: got ovr=%b pc=%h addr=%h want ovr=1 pc=300 addr=300",
               overrun, pc, bus.PC_FETCH_Req_Addr);
    end
    accept("ovr_a");
    respond(32'h5555_5555, "ovr_a");
    checks++;
    if (pc !== 32'h400 || bus.PC_FETCH_Req_Valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_kept: got pc=%h rv=%b want pc=400 rv=1", pc, bus.PC_FETCH_Req_Valid);
    end
    accept("ovr_b");
    respond(32'h6666_6666, "ovr_b");
    tick();
    checks++;
    if (bus.PC_FETCH_Req_Valid !== 1'b0 || overrun !== 1'b1 || pc !== 32'h400) begin
      errors++;
      $display("FAIL ovr_sticky: got rv=%b ovr=%b pc=%h want rv=0 ovr=1 pc=400",
               bus.PC_FETCH_Req_Valid, overrun, pc);
    end
  endtask

  task automatic test_wrap();
    advance(1'b1, 32'hFFFF_FFFC);
    accept("wrap_a");
    respond(32'h7777_7777, "wrap_a");
    advance(1'b0, '0);
    checks++;
    if (pc !== 32'h0 || bus.PC_FETCH_Req_Addr !== 32'h0 || bus.PC_FETCH_Req_Valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pc: got pc=%h addr=%h rv=%b want pc=0 addr=0 rv=1",
               pc, bus.PC_FETCH_Req_Addr, bus.PC_FETCH_Req_Valid);
    end
    accept("wrap_b");
    respond(32'h8888_8888, "wrap_b");
  endtask

  task automatic test_ignore_rsp();
    tick();
    bus.PC_FETCH_Rsp_Valid = 1'b1;
    bus.PC_FETCH_Rsp_Data  = 32'hDEAD_BEEF;
    tick();
    bus.PC_FETCH_Rsp_Valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== last_instr || bus.PC_FETCH_Req_Valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_rsp: got iv=%b instr=%h rv=%b want iv=0 instr=%h rv=0",
               instr_valid, instr, bus.PC_FETCH_Req_Valid, last_instr);
    end
  endtask

  task automatic test_reset_mid();
    advance(1'b0, '0);
    accept("rmid");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || overrun !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got pc=%h instr=%h ovr=%b iv=%b want all 0",
               pc, instr, overrun, instr_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    bus.PC_FETCH_Rsp_Valid = 1'b1;
    bus.PC_FETCH_Rsp_Data  = 32'h9999_9999;
    tick();
    bus.PC_FETCH_Rsp_Valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0 || bus.PC_FETCH_Req_Valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_late_rsp: got iv=%b instr=%h pc=%h rv=%b want 0/0/0/0",
               instr_valid, instr, pc, bus.PC_FETCH_Req_Valid);
    end
  endtask

`ifdef PC_FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    checks++;
    if (misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_init: got %b want 0", misalign);
    end
    advance(1'b1, 32'h102);
    checks++;
    if (misalign !== 1'b1 || bus.PC_FETCH_Req_Valid !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL misalign_drop: got mis=%b rv=%b pc=%h want mis=1 rv=0 pc=0",
               misalign, bus.PC_FETCH_Req_Valid, pc);
    end
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    set_en = 1'b0;
    load   = 1'b0;
    target = '0;
    bus.PC_FETCH_Req_Ready = 1'b0;
    bus.PC_FETCH_Rsp_Valid = 1'b0;
    bus.PC_FETCH_Rsp_Data  = '0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_incr();
    test_load_stall();
    test_pending();
    test_same_cycle();
    test_overrun();
    test_wrap();
    test_ignore_rsp();
    test_reset_mid();
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pc_fetch

`default_nettype wire
